// File: rtl/bpu_pkg.sv
// Shared definitions for the branch target buffer: counter encodings and
// the layout of one table entry.
package bpu_pkg;

    localparam int BPU_IDX_W = 4;
    localparam int BPU_TAG_W = 32 - BPU_IDX_W - 2;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    typedef struct packed {
        logic                 valid;
        logic [BPU_TAG_W-1:0] tag;
        logic [29:0]          target;
        logic [1:0]           ctr;
    } bpu_entry_t;

endpackage

// File: rtl/bpu_btb_if.sv
// Lookup and resolve-update signals between fetch/EX and the branch target buffer.
// The update side is valid-only: EX_br_valid qualifies the EX_br_* fields for
// one cycle and is always accepted (there is no ready), at most one per cycle.
interface bpu_btb_if;

    logic [31:0] IF_pc;
    logic        BPU_taken;
    logic [31:0] BPU_target;

    logic        EX_br_valid;
    logic [31:0] EX_br_pc;
    logic        EX_br_taken;
    logic [31:0] EX_br_target;
    logic        EX_br_pred_taken;

    logic [31:0] BPU_br_cnt;
    logic [31:0] BPU_miss_cnt;

    modport master (
        output IF_pc, EX_br_valid, EX_br_pc, EX_br_taken, EX_br_target, EX_br_pred_taken,
        input  BPU_taken, BPU_target, BPU_br_cnt, BPU_miss_cnt
    );

    modport slave (
        input  IF_pc, EX_br_valid, EX_br_pc, EX_br_taken, EX_br_target, EX_br_pred_taken,
        output BPU_taken, BPU_target, BPU_br_cnt, BPU_miss_cnt
    );

endinterface

// File: rtl/bpu_ctr2.sv
// 2-bit saturating direction counter next-state: step toward taken or not-taken,
// holding at the strong ends.
module bpu_ctr2
    import bpu_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_next_o
);

    always_comb begin
        ctr_next_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) ctr_next_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_SNT) ctr_next_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with per-entry 2-bit direction counters,
// combinational lookup, EX-side update and branch/misprediction statistics.
module bpu_btb
    import bpu_pkg::*;
#(
    parameter int IDX_W = BPU_IDX_W,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic      clk,
    input  logic      reset,
    bpu_btb_if.slave  bus
);

    localparam int NUM_ENTRIES = 1 << IDX_W;

    bpu_entry_t       tbl_q [NUM_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    bpu_entry_t       lk_entry;
    logic             lk_hit;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    bpu_entry_t       up_entry;
    logic             up_hit;
    logic [1:0]       up_ctr_next;
    bpu_entry_t       upd_entry_d;
    logic             upd_we_d;

    logic [31:0]      br_cnt_q, br_cnt_d;
    logic [31:0]      miss_cnt_q, miss_cnt_d;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{bus.IF_pc[1:0], bus.EX_br_pc[1:0], bus.EX_br_target[1:0]};

    // Lookup reads the flops directly, so a same-cycle update is not visible here.
    always_comb begin
        lk_idx   = bus.IF_pc[IDX_W+1:2];
        lk_tag   = bus.IF_pc[31:IDX_W+2];
        lk_entry = tbl_q[lk_idx];
        lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
    end

    assign bus.BPU_taken  = lk_hit && lk_entry.ctr[1];
    assign bus.BPU_target = lk_hit ? {lk_entry.target, 2'b00} : 32'h0;

    always_comb begin
        up_idx   = bus.EX_br_pc[IDX_W+1:2];
        up_tag   = bus.EX_br_pc[31:IDX_W+2];
        up_entry = tbl_q[up_idx];
        up_hit   = up_entry.valid && (up_entry.tag == up_tag);
    end

    bpu_ctr2 u_ctr2 (
        .ctr_i      (up_entry.ctr),
        .taken_i    (bus.EX_br_taken),
        .ctr_next_o (up_ctr_next)
    );

    // A not-taken branch that misses leaves the table alone; a taken one evicts.
    always_comb begin
        upd_we_d    = 1'b0;
        upd_entry_d = up_entry;
        if (bus.EX_br_valid) begin
            if (up_hit) begin
                upd_we_d        = 1'b1;
                upd_entry_d.ctr = up_ctr_next;
                if (bus.EX_br_taken) upd_entry_d.target = bus.EX_br_target[31:2];
            end else if (bus.EX_br_taken) begin
                upd_we_d           = 1'b1;
                upd_entry_d.valid  = 1'b1;
                upd_entry_d.tag    = up_tag;
                upd_entry_d.target = bus.EX_br_target[31:2];
                upd_entry_d.ctr    = CTR_ALLOC;
            end
        end
    end

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (bus.EX_br_valid) begin
            if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
            if ((bus.EX_br_pred_taken != bus.EX_br_taken) && (miss_cnt_q != 32'hFFFF_FFFF))
                miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_q[i].valid  <= 1'b0;
                tbl_q[i].tag    <= '0;
                tbl_q[i].target <= '0;
                tbl_q[i].ctr    <= CTR_WNT;
            end
            br_cnt_q   <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            if (upd_we_d) tbl_q[up_idx] <= upd_entry_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.BPU_br_cnt   = br_cnt_q;
    assign bus.BPU_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_bpu_btb.sv
// Directed plus randomized stimulus for bpu_btb against a behavioural BTB model,
// with expected values queued at drive time and popped at each check.
module tb_bpu_btb;

    logic clk;
    logic reset;

    bpu_btb_if bus ();

    bpu_btb #(.IDX_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [29:0] m_tgt   [16];
    logic [1:0]  m_ctr   [16];
    logic [31:0] m_br;
    logic [31:0] m_miss;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 2'b01;
        end
        m_br   = 32'd0;
        m_miss = 32'd0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
        logic [3:0] idx;
        logic       hit;
        idx = pc[5:2];
        hit = m_valid[idx] && (m_tag[idx] == pc[31:6]);
        tk  = hit && m_ctr[idx][1];
        tgt = hit ? {m_tgt[idx], 2'b00} : 32'h0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                                input logic pred);
        logic [3:0] idx;
        idx = pc[5:2];
        if (m_valid[idx] && (m_tag[idx] == pc[31:6])) begin
            if (tk) begin
                if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'd1;
                m_tgt[idx] = tgt[31:2];
            end else if (m_ctr[idx] != 2'b00) begin
                m_ctr[idx] = m_ctr[idx] - 2'd1;
            end
        end else if (tk) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = pc[31:6];
            m_tgt[idx]   = tgt[31:2];
            m_ctr[idx]   = 2'b10;
        end
        if (m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
        if ((pred != tk) && (m_miss != 32'hFFFF_FFFF)) m_miss = m_miss + 32'd1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic check_lookup(input string tag);
        logic        e_tk;
        logic [31:0] e_tgt;
        model_lookup(bus.IF_pc, e_tk, e_tgt);
        exp_q.push_back({31'd0, e_tk});
        exp_q.push_back(e_tgt);
        check({tag, ".taken"}, {31'd0, bus.BPU_taken});
        check({tag, ".target"}, bus.BPU_target);
    endtask

    // One clock cycle: drive at the falling edge, check mid-low phase, then
    // advance the model to what the next rising edge should commit.
    task automatic step(input string tag, input logic rst, input logic v, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt, input logic pred,
                        input logic [31:0] look_pc);
        @(negedge clk);
        reset                = rst;
        bus.EX_br_valid      = v;
        bus.EX_br_pc         = pc;
        bus.EX_br_taken      = tk;
        bus.EX_br_target     = tgt;
        bus.EX_br_pred_taken = pred;
        bus.IF_pc            = look_pc;
        #2;
        check_lookup(tag);
        exp_q.push_back(m_br);
        exp_q.push_back(m_miss);
        check({tag, ".br_cnt"}, bus.BPU_br_cnt);
        check({tag, ".miss_cnt"}, bus.BPU_miss_cnt);
        if (rst) model_reset();
        else if (v) model_update(pc, tk, tgt, pred);
    endtask

    // Extra lookup within the current cycle; only used after steps with no update.
    task automatic peek(input string tag, input logic [31:0] look_pc);
        bus.IF_pc = look_pc;
        #1;
        check_lookup(tag);
    endtask

    localparam logic [31:0] PC10 = 32'hBFC0_0010;
    localparam logic [31:0] PC50 = 32'hBFC0_0050;
    localparam logic [31:0] PC90 = 32'hBFC0_0090;
    localparam logic [31:0] PC20 = 32'hBFC0_0020;
    localparam logic [31:0] PC60 = 32'hBFC0_0060;

    initial begin
        logic [31:0] pcs [5];
        pcs[0] = PC10; pcs[1] = PC50; pcs[2] = PC90; pcs[3] = PC20; pcs[4] = PC60;

        reset                = 1'b1;
        bus.IF_pc            = 32'h0;
        bus.EX_br_valid      = 1'b0;
        bus.EX_br_pc         = 32'h0;
        bus.EX_br_taken      = 1'b0;
        bus.EX_br_target     = 32'h0;
        bus.EX_br_pred_taken = 1'b0;
        model_reset();

        step("reset",     1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, PC10);
        step("post_rst",  1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, PC10);

        step("alloc",     1'b0, 1'b1, PC10, 1'b1, 32'hBFC0_0100, 1'b0, PC10);
        step("alloc_vis", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, PC10);
        exp_q.push_back(32'hBFC0_0100);
        check("alloc_target_const", bus.BPU_target);

        step("nt1",       1'b0, 1'b1, PC10, 1'b0, 32'hDEAD_0000, 1'b1, PC10);
        step("nt2",       1'b0, 1'b1, PC10, 1'b0, 32'hDEAD_0000, 1'b0, PC10);
        step("nt3_sat",   1'b0, 1'b1, PC10, 1'b0, 32'hDEAD_0000, 1'b0, PC10);
        step("tk1",       1'b0, 1'b1, PC10, 1'b1, 32'hBFC0_0180, 1'b0, PC10);
        step("tk2",       1'b0, 1'b1, PC10, 1'b1, 32'hBFC0_0180, 1'b0, PC10);
        step("tk2_vis",   1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, PC10);
        exp_q.push_back(32'd1);
        check("sat_taken_const", {31'd0, bus.BPU_taken});

        step("alias_miss", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, PC50);
        step("alias_alloc", 1'b0, 1'b1, PC50, 1'b1, 32'hBFC0_0200, 1'b1, PC50);
        step("alias_new", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, PC50);
        peek("alias_old", PC10);
        step("nt_miss",   1'b0, 1'b1, PC90, 1'b0, 32'hBFC0_0300, 1'b0, PC90);
        step("nt_after",  1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, PC90);
        peek("nt_keep",   PC50);

        step("st_rst",    1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, PC10);
        step("st_u1",     1'b0, 1'b1, PC20, 1'b1, 32'hBFC0_0400, 1'b0, PC20);
        step("st_u2",     1'b0, 1'b1, PC20, 1'b1, 32'hBFC0_0400, 1'b1, PC20);
        step("st_u3",     1'b0, 1'b1, PC20, 1'b0, 32'hBFC0_0400, 1'b1, PC20);
        step("st_done",   1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, PC20);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd2);
        check("stats_br_const", bus.BPU_br_cnt);
        check("stats_miss_const", bus.BPU_miss_cnt);

        step("mid_rst",   1'b1, 1'b1, 32'hBFC0_0300, 1'b1, 32'hBFC0_0500, 1'b0, PC20);
        step("mid_after", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hBFC0_0300);
        peek("mid_old",   PC20);
        exp_q.push_back(32'd0);
        check("mid_br_const", bus.BPU_br_cnt);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] rpc, rlk, rtgt;
            logic        rtk, rpred, rv;
            rv    = ($urandom_range(0, 3) != 0);
            rpc   = pcs[$urandom_range(0, 4)];
            rlk   = pcs[$urandom_range(0, 4)];
            rtk   = $urandom_range(0, 1) == 1;
            rpred = $urandom_range(0, 1) == 1;
            rtgt  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            step("rand", 1'b0, rv, rpc, rtk, rtgt, rpred, rlk);
        end
        step("rand_end", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, PC10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
